// File: rtl/eflags_wb_if.sv
// Execute/writeback flag-update bus between the issuing stage and eflags_wb.
// The master drives execute-side requests and memory data; the slave returns flags and status.
interface eflags_wb_if;
  logic        ex_valid;
  logic        wb_stall;
  logic        ex_ready;
  logic        flush;
  logic [5:0]  alu1_flags;
  logic [5:0]  cmps_flags;
  logic [5:0]  ld_flags;
  logic        ld_df;
  logic        df_val_ex;
  logic        cmps_start;
  logic        mem_rd_valid;
  logic [31:0] mem_out;
  logic [31:0] mem_out_latched;
  logic        cmps_busy;
  logic [31:0] eflags;
  logic        CF_out;
  logic        AF_out;
  logic        DF_out;

  modport master (
    output ex_valid, wb_stall, flush, alu1_flags, cmps_flags, ld_flags,
           ld_df, df_val_ex, cmps_start, mem_rd_valid, mem_out,
    input  ex_ready, mem_out_latched, cmps_busy, eflags, CF_out, AF_out, DF_out
  );

  modport slave (
    input  ex_valid, wb_stall, flush, alu1_flags, cmps_flags, ld_flags,
           ld_df, df_val_ex, cmps_start, mem_rd_valid, mem_out,
    output ex_ready, mem_out_latched, cmps_busy, eflags, CF_out, AF_out, DF_out
  );
endinterface

// File: rtl/eflags_wb.sv
// Architectural EFLAGS register with masked ALU writeback and a two-read CMPS sequencer.
// State table:  IDLE | no CMPS in flight ;  WAIT_A | awaiting first operand ;  WAIT_B | awaiting second read, then flag write
module eflags_wb (
  input  logic        clk,
  input  logic        rst,
  eflags_wb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

  state_t      state_q;
  logic [5:0]  flags_q;          // {OF,SF,ZF,AF,PF,CF}
  logic        df_q;
  logic [5:0]  mask_q;
  logic [31:0] mem_out_latched_q;

  logic        cmps_busy;
  logic        ex_ready;
  logic        accept;
  logic [5:0]  flags_alu_d;
  logic [5:0]  flags_cmps_d;

  assign cmps_busy    = (state_q != IDLE);
  assign ex_ready     = !bus.wb_stall && !cmps_busy;
  assign accept       = bus.ex_valid && ex_ready;
  assign flags_alu_d  = (flags_q & ~bus.ld_flags) | (bus.alu1_flags & bus.ld_flags);
  assign flags_cmps_d = (flags_q & ~mask_q) | (bus.cmps_flags & mask_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      flags_q           <= '0;
      df_q              <= 1'b0;
      mask_q            <= '0;
      mem_out_latched_q <= '0;
    end else if (bus.flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (bus.ld_df) df_q <= bus.df_val_ex;
            if (bus.cmps_start) begin
              mask_q  <= bus.ld_flags;
              state_q <= WAIT_A;
            end else begin
              flags_q <= flags_alu_d;
            end
          end
        end
        WAIT_A: begin
          if (bus.mem_rd_valid) begin
            mem_out_latched_q <= bus.mem_out;
            state_q           <= WAIT_B;
          end
        end
        WAIT_B: begin
          // A stalled writeback holds the compare result even if the read has arrived.
          if (bus.mem_rd_valid && !bus.wb_stall) begin
            flags_q <= flags_cmps_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ex_ready        = ex_ready;
  assign bus.cmps_busy       = cmps_busy;
  assign bus.mem_out_latched = mem_out_latched_q;
  assign bus.eflags = {20'b0, flags_q[5], df_q, 2'b0, flags_q[4], flags_q[3], 1'b0,
                       flags_q[2], 1'b0, flags_q[1], 1'b1, flags_q[0]};
  assign bus.CF_out = flags_q[0];
  assign bus.AF_out = flags_q[2];
  assign bus.DF_out = df_q;

endmodule

// File: tb/tb_eflags_wb.sv
// Randomized self-checking bench for eflags_wb against an architectural-level flags model.
module tb_eflags_wb;

  logic clk;
  logic rst;
  eflags_wb_if bus();

  eflags_wb dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: eflags kept as the 32-bit architectural image, phase counts CMPS reads seen.
  logic [31:0] m_ef;
  logic [31:0] m_lat;
  logic [5:0]  m_mask;
  int          m_phase;
  int          pos [6] = '{0, 2, 4, 6, 7, 11};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ef = 32'h0000_0002;
    m_lat = '0;
    m_mask = '0;
    m_phase = 0;
  endtask

  task automatic check_outputs();
    chk("eflags", bus.eflags, m_ef);
    chk("cmps_busy", 32'(bus.cmps_busy), 32'(m_phase != 0));
    chk("mem_out_latched", bus.mem_out_latched, m_lat);
    chk("CF_out", 32'(bus.CF_out), 32'(m_ef[0]));
    chk("AF_out", 32'(bus.AF_out), 32'(m_ef[4]));
    chk("DF_out", 32'(bus.DF_out), 32'(m_ef[10]));
  endtask

  // Applies one cycle of inputs just after a falling edge, updates the model, and checks at the next falling edge.
  task automatic step(input logic r, input logic ev, input logic st, input logic fl,
                      input logic cs, input logic mrv, input logic ldf, input logic dfv,
                      input logic [5:0] alu, input logic [5:0] cmpf, input logic [5:0] ld,
                      input logic [31:0] mo);
    logic acc;
    rst = r;
    bus.ex_valid = ev;     bus.wb_stall = st;    bus.flush = fl;
    bus.cmps_start = cs;   bus.mem_rd_valid = mrv;
    bus.ld_df = ldf;       bus.df_val_ex = dfv;
    bus.alu1_flags = alu;  bus.cmps_flags = cmpf; bus.ld_flags = ld;
    bus.mem_out = mo;
    #1;
    if (r) begin
      model_reset();
      chk("ex_ready_rst", 32'(bus.ex_ready), 32'(!st));
      check_outputs();
    end else begin
      chk("ex_ready", 32'(bus.ex_ready), 32'(!st && m_phase == 0));
      acc = ev && !st && (m_phase == 0);
      if (fl) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (acc) begin
          if (ldf) m_ef[10] = dfv;
          if (cs) begin
            m_mask = ld;
            m_phase = 1;
          end else begin
            for (int i = 0; i < 6; i++) if (ld[i]) m_ef[pos[i]] = alu[i];
          end
        end
      end else if (m_phase == 1) begin
        if (mrv) begin
          m_lat = mo;
          m_phase = 2;
        end
      end else begin
        if (mrv && !st) begin
          for (int i = 0; i < 6; i++) if (m_mask[i]) m_ef[pos[i]] = cmpf[i];
          m_phase = 0;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b0;
    bus.ex_valid = 0; bus.wb_stall = 0; bus.flush = 0; bus.cmps_start = 0;
    bus.mem_rd_valid = 0; bus.ld_df = 0; bus.df_val_ex = 0;
    bus.alu1_flags = '0; bus.cmps_flags = '0; bus.ld_flags = '0; bus.mem_out = '0;
    model_reset();
    @(negedge clk);

    step(1, 0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 6'h00, 32'h0);
    chk("reset_eflags", bus.eflags, 32'h0000_0002);
    chk("reset_busy", 32'(bus.cmps_busy), 32'h0);
    chk("reset_lat", bus.mem_out_latched, 32'h0);

    step(0, 1, 0, 0, 0, 0, 0, 0, 6'h3F, 6'h00, 6'h09, 32'h0);
    chk("masked_update", bus.eflags, 32'h0000_0043);

    bus.wb_stall = 1'b1; #1;
    chk("stall_ready", 32'(bus.ex_ready), 32'h0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 6'h3F, 32'h0);
    chk("stall_hold", bus.eflags, 32'h0000_0043);

    step(0, 1, 0, 0, 1, 0, 0, 0, 6'h00, 6'h00, 6'h3F, 32'h0);
    chk("cmps_busy_a", 32'(bus.cmps_busy), 32'h1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 6'h00, 6'h00, 6'h00, 32'h1234_5678);
    chk("cmps_latch", bus.mem_out_latched, 32'h1234_5678);
    step(0, 0, 1, 0, 0, 1, 0, 0, 6'h00, 6'h08, 6'h00, 32'hDEAD_BEEF);
    chk("cmps_wb_stall", bus.eflags, 32'h0000_0043);
    step(0, 0, 0, 0, 0, 1, 0, 0, 6'h00, 6'h08, 6'h00, 32'hDEAD_BEEF);
    chk("cmps_flags", bus.eflags, 32'h0000_0042);
    chk("cmps_done", 32'(bus.cmps_busy), 32'h0);
    chk("cmps_lat_hold", bus.mem_out_latched, 32'h1234_5678);

    step(0, 1, 0, 0, 1, 0, 0, 0, 6'h00, 6'h00, 6'h3F, 32'h0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 6'h00, 6'h00, 6'h00, 32'hCAFE_0001);
    step(0, 0, 0, 1, 0, 1, 0, 0, 6'h00, 6'h3F, 6'h00, 32'h0);
    chk("flush_flags", bus.eflags, 32'h0000_0042);
    chk("flush_idle", 32'(bus.cmps_busy), 32'h0);
    chk("flush_lat", bus.mem_out_latched, 32'hCAFE_0001);

    step(0, 1, 0, 0, 0, 0, 1, 1, 6'h00, 6'h00, 6'h00, 32'h0);
    chk("df_bit", 32'(bus.eflags[10]), 32'h1);
    chk("df_out", 32'(bus.DF_out), 32'h1);

    step(0, 1, 0, 0, 1, 0, 0, 0, 6'h00, 6'h00, 6'h3F, 32'h0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 6'h00, 6'h3F, 6'h00, 32'h5555_5555);
    chk("rst_mid_cmps", bus.eflags, 32'h0000_0002);
    chk("rst_mid_busy", 32'(bus.cmps_busy), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 1) == 1,
           6'($urandom), 6'($urandom), 6'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/eflags_wb.md
EFLAGS_WB -- requirements
Module: eflags_wb

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ex_valid, input, 1 bit: an execute-stage instruction is presented this cycle.
REQ-004 SHALL have port wb_stall, input, 1 bit: downstream writeback cannot accept.
REQ-005 SHALL have port ex_ready, output, 1 bit: the presented instruction is accepted this cycle.
REQ-006 SHALL have port flush, input, 1 bit: squash in-flight work.
REQ-007 SHALL have port alu1_flags, input, 6 bits: ALU flags {OF,SF,ZF,AF,PF,CF}.
REQ-008 SHALL have port cmps_flags, input, 6 bits: CMPS compare flags, same ordering.
REQ-009 SHALL have port ld_flags, input, 6 bits: per-flag load enables, same ordering.
REQ-010 SHALL have port ld_df, input, 1 bit: load DF from df_val_ex.
REQ-011 SHALL have port df_val_ex, input, 1 bit: new DF value.
REQ-012 SHALL have port cmps_start, input, 1 bit: the presented instruction is CMPS.
REQ-013 SHALL have port mem_rd_valid, input, 1 bit: mem_out carries valid read data.
REQ-014 SHALL have port mem_out, input, 32 bits: memory read data.
REQ-015 SHALL have port mem_out_latched, output, 32 bits: captured first CMPS operand.
REQ-016 SHALL have port cmps_busy, output, 1 bit: the CMPS sequencer is not IDLE.
REQ-017 SHALL have port eflags, output, 32 bits: architectural flags register.
REQ-018 SHALL have ports CF_out, AF_out, DF_out, output, 1 bit each: registered eflags bits 0, 4, 10, fed back to the ALU CF_in, AF_in and DF_in inputs.

Function
REQ-019 SHALL map eflags bits as: CF=0, PF=2, AF=4, ZF=6, SF=7, DF=10, OF=11; bit 1 SHALL read 1; all other bits SHALL read 0.
REQ-020 SHALL drive ex_ready = !wb_stall && !cmps_busy.
REQ-021 SHALL define accept = ex_valid && ex_ready.
REQ-022 On accept with cmps_start=0, SHALL update every flag whose ld_flags bit is 1 from alu1_flags at the next edge; flags with ld_flags bit 0 SHALL hold.
REQ-023 On accept with ld_df=1, SHALL write DF <= df_val_ex at the next edge.
REQ-024 SHALL register eflags with one-cycle latency and no combinational bypass; CF_out, AF_out and DF_out SHALL be taken from the register.
REQ-025 CMPS sequencer SHALL have states IDLE, WAIT_A and WAIT_B.
REQ-026 IDLE -> WAIT_A on accept with cmps_start=1; SHALL latch ld_flags into an internal mask; no flag update that cycle.
REQ-027 In WAIT_A, on mem_rd_valid, SHALL capture mem_out_latched <= mem_out and move to WAIT_B; otherwise hold.
REQ-028 In WAIT_B, on mem_rd_valid, SHALL write the masked flags from cmps_flags and move to IDLE; otherwise hold.
REQ-029 In WAIT_B, SHALL hold the flag update and state while wb_stall=1, even if mem_rd_valid=1.
REQ-030 mem_out_latched SHALL change only on WAIT_A capture and SHALL hold at all other times.
REQ-031 flush SHALL take priority over all other events: state -> IDLE, no flag write that cycle, mem_out_latched held.
REQ-032 SHALL ignore mem_rd_valid in IDLE.
REQ-033 SHALL assert cmps_busy = (state != IDLE).

Reset
REQ-034 While rst=1, SHALL hold: eflags = 32'h0000_0002, state = IDLE, mem_out_latched = 0, internal mask = 0.
REQ-035 While rst=1, SHALL drive ex_ready = !wb_stall, cmps_busy = 0, and CF_out = AF_out = DF_out = 0.
REQ-036 Reset asserted mid-CMPS SHALL abandon the sequence and write no flags.

Verification
REQ-037 Reset: assert rst -> eflags=0x00000002, cmps_busy=0, mem_out_latched=0.
REQ-038 Masked update: ex_valid=1, wb_stall=0, alu1_flags=6'b111111, ld_flags=6'b001001 -> next cycle eflags=0x00000043 (CF, ZF set, bit 1).
REQ-039 Stall: the same stimulus with wb_stall=1 -> ex_ready=0 and eflags unchanged.
REQ-040 CMPS: accept cmps_start=1, ld_flags=6'h3F; mem_rd_valid with mem_out=0x12345678 -> mem_out_latched=0x12345678; second mem_rd_valid with cmps_flags=6'b001000 -> eflags=0x00000042, cmps_busy=0.
REQ-041 Flush in WAIT_B coincident with mem_rd_valid -> state IDLE, eflags unchanged.
REQ-042 DF: accept with ld_df=1, df_val_ex=1 -> eflags bit 10 = 1 and DF_out = 1 one cycle later.
